// File: rtl/uart_line_echo.sv
// Line-editing echo stage: collects RX bytes into a line buffer with backspace
// editing, then replays the line followed by CR LF into the UART TX FIFO.
module uart_line_echo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_ready,
   input  logic [WIDTH-1:0] rx_data,
   input  logic             parity_err,
   output logic             rx_req,
   input  logic             tx_ready,
   output logic             tx_req,
   output logic [WIDTH-1:0] tx_din,
   output logic [CNT_W-1:0] line_len,
   output logic             overflow,
   output logic [7:0]       err_cnt,
   output logic             busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [WIDTH-1:0] CHR_CR  = WIDTH'(13);
   localparam logic [WIDTH-1:0] CHR_LF  = WIDTH'(10);
   localparam logic [WIDTH-1:0] CHR_BS  = WIDTH'(8);
   localparam logic [WIDTH-1:0] CHR_DEL = WIDTH'(127);

   typedef enum logic [1:0] {
      COLLECT,
      SEND_LINE,
      SEND_CR,
      SEND_LF
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] lineLen_q, lineLen_d;
   logic [CNT_W-1:0] rdPtr_q, rdPtr_d;
   logic             overflow_q, overflow_d;
   logic [7:0]       errCnt_q, errCnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             memWe;
   logic             rxReq, txReq;
   logic [WIDTH-1:0] txDin;

   // Byte classification in COLLECT follows a strict priority: parity error,
   // CR, LF, backspace/delete, then printable.
   always_comb begin
      state_d    = state_q;
      lineLen_d  = lineLen_q;
      rdPtr_d    = rdPtr_q;
      overflow_d = overflow_q;
      errCnt_d   = errCnt_q;
      memWe      = 1'b0;
      rxReq      = 1'b0;
      txReq      = 1'b0;
      txDin      = '0;
      case (state_q)
         COLLECT: begin
            rxReq = rx_ready;
            if (rx_ready) begin
               if (parity_err) begin
                  if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
               end else if (rx_data == CHR_CR) begin
                  state_d = (lineLen_q != '0) ? SEND_LINE : SEND_CR;
                  rdPtr_d = '0;
               end else if (rx_data == CHR_LF) begin
                  state_d = COLLECT;
               end else if (rx_data == CHR_BS || rx_data == CHR_DEL) begin
                  if (lineLen_q != '0) lineLen_d = lineLen_q - ONE_C;
               end else if (lineLen_q < DEPTH_C) begin
                  memWe     = 1'b1;
                  lineLen_d = lineLen_q + ONE_C;
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         SEND_LINE: begin
            txDin = mem_q[rdPtr_q[IDX_W-1:0]];
            txReq = tx_ready;
            if (tx_ready) begin
               rdPtr_d = rdPtr_q + ONE_C;
               if (rdPtr_q == lineLen_q - ONE_C) state_d = SEND_CR;
            end
         end
         SEND_CR: begin
            txDin = CHR_CR;
            txReq = tx_ready;
            if (tx_ready) state_d = SEND_LF;
         end
         SEND_LF: begin
            txDin = CHR_LF;
            txReq = tx_ready;
            if (tx_ready) begin
               state_d    = COLLECT;
               lineLen_d  = '0;
               rdPtr_d    = '0;
               overflow_d = 1'b0;
            end
         end
         default: state_d = COLLECT;
      endcase
      if (rst) begin
         rxReq = 1'b0;
         txReq = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= COLLECT;
         lineLen_q  <= '0;
         rdPtr_q    <= '0;
         overflow_q <= 1'b0;
         errCnt_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         lineLen_q  <= lineLen_d;
         rdPtr_q    <= rdPtr_d;
         overflow_q <= overflow_d;
         errCnt_q   <= errCnt_d;
      end
   end

   // Buffer contents are deliberately left unreset; line_len alone defines validity.
   always_ff @(posedge clk) begin
      if (memWe) mem_q[lineLen_q[IDX_W-1:0]] <= rx_data;
   end

   assign rx_req   = rxReq;
   assign tx_req   = txReq;
   assign tx_din   = txDin;
   assign line_len = lineLen_q;
   assign overflow = overflow_q;
   assign err_cnt  = errCnt_q;
   assign busy     = (state_q != COLLECT);

endmodule
